// File: rtl/conv_ctrl_if.sv
// Weight/pixel input streams and the registered pixel stream toward the conv engine.
interface conv_ctrl_if;
   logic              w_valid;
   logic signed [7:0] w_data;
   logic              w_ready;
   logic              pix_valid;
   logic [7:0]        pix_data;
   logic              pix_ready;
   logic              conv_valid_o;
   logic [7:0]        conv_data_o;

   modport master (
      output w_valid, w_data, pix_valid, pix_data,
      input  w_ready, pix_ready, conv_valid_o, conv_data_o
   );

   modport slave (
      input  w_valid, w_data, pix_valid, pix_data,
      output w_ready, pix_ready, conv_valid_o, conv_data_o
   );
endinterface

// File: rtl/conv_ctrl.sv
// Job sequencer for the conv engine: per channel, load 9 kernel taps, stream
// PIX_PER_CHNL pixels with one-cycle registered latency, then wait for channel done.
module conv_ctrl #(
   parameter int PIX_PER_CHNL = 64,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [7:0]        cfg_chnl_num,
   input  logic              conv_chnl_done,
   conv_ctrl_if.slave        s,
   output logic signed [7:0] weight1,
   output logic signed [7:0] weight2,
   output logic signed [7:0] weight3,
   output logic signed [7:0] weight4,
   output logic signed [7:0] weight5,
   output logic signed [7:0] weight6,
   output logic signed [7:0] weight7,
   output logic signed [7:0] weight8,
   output logic signed [7:0] weight9,
   output logic              busy,
   output logic              done,
   output logic [7:0]        chnl_idx
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_W = 3'd1;
   localparam logic [2:0] S_STREAM = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_FIN    = 3'd4;

   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_PER_CHNL - 1);

   logic [2:0]       state_q, state_d;
   logic [7:0]       n_q, n_d;
   logic [7:0]       chnl_q, chnl_d;
   logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [3:0]       w_idx_q, w_idx_d;
   logic             flag_q, flag_d;
   logic [8:0][7:0]  wts_q, wts_d;
   logic             conv_valid_q, conv_valid_d;
   logic [7:0]       conv_data_q, conv_data_d;
   logic             w_hs, pix_hs;

   assign w_hs   = s.w_valid   && (state_q == S_LOAD_W);
   assign pix_hs = s.pix_valid && (state_q == S_STREAM);

   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      chnl_d       = chnl_q;
      pix_cnt_d    = pix_cnt_q;
      w_idx_d      = w_idx_q;
      flag_d       = flag_q;
      wts_d        = wts_q;
      conv_valid_d = 1'b0;
      conv_data_d  = conv_data_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cfg_chnl_num != 8'd0) begin
                  n_d       = cfg_chnl_num;
                  chnl_d    = 8'd0;
                  pix_cnt_d = '0;
                  w_idx_d   = 4'd0;
                  flag_d    = 1'b0;
                  state_d   = S_LOAD_W;
               end else begin
                  state_d   = S_FIN;
               end
            end
         end
         S_LOAD_W: begin
            if (w_hs) begin
               wts_d[w_idx_q] = s.w_data;
               if (w_idx_q == 4'd8) begin
                  w_idx_d = 4'd0;
                  state_d = S_STREAM;
               end else begin
                  w_idx_d = w_idx_q + 4'd1;
               end
            end
         end
         S_STREAM: begin
            if (conv_chnl_done) flag_d = 1'b1;
            if (pix_hs) begin
               conv_valid_d = 1'b1;
               conv_data_d  = s.pix_data;
               if (pix_cnt_q == LAST_PIX) begin
                  pix_cnt_d = '0;
                  state_d   = S_DRAIN;
               end else begin
                  pix_cnt_d = pix_cnt_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            // A done pulse that arrived while streaming is remembered in flag_q.
            if (flag_q || conv_chnl_done) begin
               flag_d    = 1'b0;
               pix_cnt_d = '0;
               w_idx_d   = 4'd0;
               if (chnl_q == n_q - 8'd1) begin
                  state_d = S_FIN;
               end else begin
                  chnl_d  = chnl_q + 8'd1;
                  state_d = S_LOAD_W;
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Abort cancels the job but keeps the taps already loaded.
      if (abort) begin
         state_d      = S_IDLE;
         conv_valid_d = 1'b0;
         flag_d       = 1'b0;
         wts_d        = wts_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         n_q          <= 8'd0;
         chnl_q       <= 8'd0;
         pix_cnt_q    <= '0;
         w_idx_q      <= 4'd0;
         flag_q       <= 1'b0;
         wts_q        <= '0;
         conv_valid_q <= 1'b0;
         conv_data_q  <= 8'd0;
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         chnl_q       <= chnl_d;
         pix_cnt_q    <= pix_cnt_d;
         w_idx_q      <= w_idx_d;
         flag_q       <= flag_d;
         wts_q        <= wts_d;
         conv_valid_q <= conv_valid_d;
         conv_data_q  <= conv_data_d;
      end
   end

   assign s.w_ready      = (state_q == S_LOAD_W);
   assign s.pix_ready    = (state_q == S_STREAM);
   assign s.conv_valid_o = conv_valid_q;
   assign s.conv_data_o  = conv_data_q;
   assign busy           = (state_q == S_LOAD_W) || (state_q == S_STREAM) || (state_q == S_DRAIN);
   assign done           = (state_q == S_FIN);
   assign chnl_idx       = chnl_q;

   assign weight1 = wts_q[0];
   assign weight2 = wts_q[1];
   assign weight3 = wts_q[2];
   assign weight4 = wts_q[3];
   assign weight5 = wts_q[4];
   assign weight6 = wts_q[5];
   assign weight7 = wts_q[6];
   assign weight8 = wts_q[7];
   assign weight9 = wts_q[8];

endmodule

// File: tb/tb_conv_ctrl.sv
// Scoreboard bench for conv_ctrl: stimulus pushes expected conv beats (data and
// cycle), an independent monitor pops and compares on every conv_valid_o.
module tb_conv_ctrl;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, conv_chnl_done = 1'b0;
   logic [7:0] cfg_chnl_num = 8'd0;
   logic signed [7:0] weight1, weight2, weight3, weight4, weight5;
   logic signed [7:0] weight6, weight7, weight8, weight9;
   logic busy, done;
   logic [7:0] chnl_idx;
   logic [71:0] taps;

   conv_ctrl_if bus();

   conv_ctrl #(.PIX_PER_CHNL(64), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_chnl_num(cfg_chnl_num), .conv_chnl_done(conv_chnl_done), .s(bus),
      .weight1(weight1), .weight2(weight2), .weight3(weight3),
      .weight4(weight4), .weight5(weight5), .weight6(weight6),
      .weight7(weight7), .weight8(weight8), .weight9(weight9),
      .busy(busy), .done(done), .chnl_idx(chnl_idx)
   );

   assign taps = {weight9, weight8, weight7, weight6, weight5,
                  weight4, weight3, weight2, weight1};

   always #5 clk = ~clk;

   typedef struct { logic [7:0] d; int c; } exp_t;
   exp_t q[$];
   int checks = 0, failures = 0, cyc = 0, conv_cnt = 0, done_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
         if (bus.conv_valid_o === 1'b1) begin
            conv_cnt++;
            chk("conv_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("conv_data", bus.conv_data_o, e.d);
               chk("conv_cycle", cyc, e.c);
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL timeout: bench did not finish within bound");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_job(input logic [7:0] n);
      start = 1'b1; cfg_chnl_num = n;
      tick();
      start = 1'b0;
   endtask

   // stray: pulse conv_chnl_done on beat 0 and start on beat 4; both must be ignored
   task automatic load_w(input logic [8:0][7:0] w, input bit gaps, input bit stray);
      for (int k = 0; k < 9; k++) begin
         if (gaps && k > 0) begin
            bus.w_valid = 1'b0; conv_chnl_done = 1'b0; start = 1'b0;
            tick();
         end
         bus.w_valid = 1'b1; bus.w_data = w[k];
         chk("w_ready", bus.w_ready, 1);
         conv_chnl_done = stray && (k == 0);
         start = stray && (k == 4);
         tick();
      end
      bus.w_valid = 1'b0; conv_chnl_done = 1'b0; start = 1'b0;
      chk("taps_loaded", taps, w);
      chk("w_ready_off", bus.w_ready, 0);
   endtask

   task automatic stream(input int first, input int npix, input bit gaps,
                         input bit done_last, input logic [71:0] w);
      for (int i = 0; i < npix; i++) begin
         if (gaps && i > 0) begin
            bus.pix_valid = 1'b0;
            tick();
         end
         bus.pix_valid = 1'b1; bus.pix_data = 8'(first + i);
         chk("pix_ready", bus.pix_ready, 1);
         q.push_back('{8'(first + i), cyc + 1});
         conv_chnl_done = done_last && (i == npix - 1);
         tick();
      end
      bus.pix_valid = 1'b0; conv_chnl_done = 1'b0;
      if (npix == 64) begin
         chk("pix_ready_drain", bus.pix_ready, 0);
         chk("busy_drain", busy, 1);
         chk("taps_stable", taps, w);
      end
   endtask

   // delay = cycle (after the last pixel handshake) where conv_chnl_done is sampled;
   // 0 means the sticky flag alone must end the channel.
   task automatic end_chnl(input int delay, input bit last, input logic [7:0] nxt);
      if (delay > 0) begin
         repeat (delay - 1) begin
            chk("drain_hold", {busy, done}, 2'b10);
            tick();
         end
         conv_chnl_done = 1'b1;
         tick();
         conv_chnl_done = 1'b0;
      end else begin
         tick();
      end
      if (last) begin
         chk("done_pulse", {busy, done}, 2'b01);
         tick();
         chk("idle_after", {busy, done}, 2'b00);
      end else begin
         chk("next_chnl", {busy, bus.w_ready, chnl_idx}, {2'b11, nxt});
      end
   endtask

   initial begin
      logic [8:0][7:0] wv;
      logic [7:0] wc [3];
      int c0, d0;
      wc[0] = 8'hFF; wc[1] = 8'd2; wc[2] = 8'd127;
      bus.w_valid = 1'b0; bus.w_data = '0; bus.pix_valid = 1'b0; bus.pix_data = '0;

      // reset state
      rst = 1'b1;
      tick(); tick();
      chk("rst_outs", {bus.conv_valid_o, busy, done, bus.w_ready, bus.pix_ready}, 0);
      chk("rst_data", bus.conv_data_o, 0);
      chk("rst_taps", taps, 0);
      chk("rst_idx", chnl_idx, 0);
      rst = 1'b0;
      tick();

      // basic single channel
      start_job(8'd1);
      chk("busy_start", {busy, chnl_idx}, {1'b1, 8'd0});
      wv = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      load_w(wv, 1'b0, 1'b0);
      stream(0, 64, 1'b0, 1'b0, wv);
      end_chnl(3, 1'b1, 8'd0);
      chk("done_cnt_basic", done_cnt, 1);
      chk("idx_hold", chnl_idx, 0);

      // three channels with distinct taps
      c0 = conv_cnt; d0 = done_cnt;
      start_job(8'd3);
      for (int c = 0; c < 3; c++) begin
         wv = {9{wc[c]}};
         chk("chnl_idx", chnl_idx, c);
         load_w(wv, 1'b0, 1'b0);
         stream(c * 50, 64, 1'b0, 1'b0, wv);
         end_chnl(2, c == 2, 8'(c + 1));
      end
      chk("conv_cnt_multi", conv_cnt - c0, 192);
      chk("done_cnt_multi", done_cnt - d0, 1);
      chk("idx_hold_multi", chnl_idx, 2);

      // gaps on both streams, stray done/start while loading
      start_job(8'd1);
      cfg_chnl_num = 8'd5;
      wv = {8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
      load_w(wv, 1'b1, 1'b1);
      stream(100, 64, 1'b1, 1'b0, wv);
      end_chnl(3, 1'b1, 8'd0);
      chk("idx_after_busy_start", chnl_idx, 0);

      // done arrives with the last pixel handshake
      start_job(8'd1);
      wv = {9{8'd3}};
      load_w(wv, 1'b0, 1'b0);
      stream(7, 64, 1'b0, 1'b1, wv);
      end_chnl(0, 1'b1, 8'd0);

      // abort at pixel 20 of channel 1
      d0 = done_cnt;
      start_job(8'd2);
      wv = {9{8'd5}};
      load_w(wv, 1'b0, 1'b0);
      stream(0, 64, 1'b0, 1'b0, wv);
      end_chnl(2, 1'b0, 8'd1);
      wv = {9{8'd7}};
      load_w(wv, 1'b0, 1'b0);
      stream(200, 20, 1'b0, 1'b0, wv);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_idle", {busy, done, bus.pix_ready, bus.conv_valid_o}, 0);
      chk("abort_taps", taps, wv);
      tick();
      chk("abort_no_done", done_cnt - d0, 0);

      // reset mid-job beats abort and start
      start_job(8'd1);
      load_w({9{8'd3}}, 1'b0, 1'b0);
      stream(0, 10, 1'b0, 1'b0, {9{8'd3}});
      rst = 1'b1; abort = 1'b1; start = 1'b1; cfg_chnl_num = 8'd1;
      tick();
      rst = 1'b0; abort = 1'b0; start = 1'b0;
      chk("rst_mid_outs", {bus.conv_valid_o, busy, done, bus.w_ready, bus.pix_ready}, 0);
      chk("rst_mid_data", bus.conv_data_o, 0);
      chk("rst_mid_taps", taps, 0);
      chk("rst_mid_idx", chnl_idx, 0);
      tick();
      chk("rst_mid_idle", {busy, done}, 0);

      // zero channels: done next cycle, no beats consumed
      bus.w_valid = 1'b1; bus.w_data = 8'sd55; bus.pix_valid = 1'b1; bus.pix_data = 8'd99;
      start_job(8'd0);
      chk("zero_fin", {busy, done, bus.w_ready, bus.pix_ready}, 4'b0100);
      tick();
      chk("zero_idle", {busy, done}, 0);
      bus.w_valid = 1'b0; bus.pix_valid = 1'b0;
      chk("zero_taps", taps, 0);

      // abort wins over start in IDLE
      abort = 1'b1; start = 1'b1; cfg_chnl_num = 8'd1;
      tick();
      abort = 1'b0; start = 1'b0;
      chk("abort_start", {busy, done, bus.w_ready}, 0);
      tick();

      chk("q_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/conv_ctrl.md
CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 SHALL have parameter PIX_PER_CHNL, default 64: pixels streamed per channel.
REQ-002 SHALL have parameter CNT_W, default 16: width of the pixel counter, with PIX_PER_CHNL <= 2^CNT_W.
REQ-003 SHALL have clk  in  1: single clock; all logic is rising-edge.
REQ-004 SHALL have rst  in  1: synchronous, active-high reset.
REQ-005 SHALL have start  in  1: pulse that begins a job; sampled in IDLE only.
REQ-006 SHALL have abort  in  1: synchronous job cancel.
REQ-007 SHALL have cfg_chnl_num  in  8: channels per job; latched on accepted start.
REQ-008 SHALL have w_valid / w_data  in  1 / 8 (signed), and w_ready  out  1: weight stream.
REQ-009 SHALL have pix_valid / pix_data  in  1 / 8, and pix_ready  out  1: pixel stream.
REQ-010 SHALL have conv_valid_o / conv_data_o  out  1 / 8: drive the conv engine valid_i / data_i.
REQ-011 SHALL have weight1..weight9  out  8 signed each: kernel taps to the conv engine.
REQ-012 SHALL have conv_chnl_done  in  1: end-of-channel pulse from the conv engine.
REQ-013 SHALL have busy  out  1, done  out  1, and chnl_idx  out  8: status outputs.

Function
REQ-014 SHALL implement states IDLE, LOAD_W, STREAM, DRAIN, FIN.
REQ-015 IDLE: start=1 with cfg_chnl_num!=0 SHALL latch N, clear chnl_idx, and go to LOAD_W; start with cfg_chnl_num=0 SHALL go to FIN.
REQ-016 LOAD_W: w_ready=1; each w_valid&w_ready beat SHALL write weight(k+1), k=0..8 in order; the 9th beat SHALL go to STREAM.
REQ-017 weight1..9 SHALL change only on LOAD_W handshakes and SHALL be stable throughout STREAM and DRAIN.
REQ-018 STREAM: pix_ready=1; each pix_valid&pix_ready beat SHALL produce, one cycle later, conv_valid_o=1 and conv_data_o=pix_data (registered, latency 1).
REQ-019 conv_valid_o SHALL be 0 in every cycle without a preceding handshake; gaps in pix_valid SHALL pass through as gaps, never filled.
REQ-020 the pixel counter SHALL increment per handshake; the PIX_PER_CHNL-th handshake SHALL deassert pix_ready the next cycle and go to DRAIN.
REQ-021 conv_chnl_done seen in STREAM or DRAIN SHALL set a sticky flag; in DRAIN, flag or input high SHALL end the channel and clear the flag.
REQ-022 at channel end: if chnl_idx==N-1, SHALL go to FIN; otherwise chnl_idx SHALL increment, the pixel and weight indices SHALL clear, and the state SHALL go to LOAD_W.
REQ-023 FIN: done=1 for exactly one cycle, then IDLE.
REQ-024 busy SHALL be 1 in LOAD_W, STREAM and DRAIN, and 0 in IDLE and FIN.
REQ-025 w_ready SHALL be 0 outside LOAD_W and pix_ready SHALL be 0 outside STREAM; no input beat SHALL be consumed in any other state.
REQ-026 start while busy SHALL be ignored; conv_chnl_done in IDLE, LOAD_W or FIN SHALL be ignored and SHALL NOT set the flag.
REQ-027 abort (any state) SHALL go to IDLE next cycle: conv_valid_o=0, sticky flag cleared, no done pulse, weights retained.
REQ-028 abort and start in the same IDLE cycle: abort SHALL win and start SHALL be dropped.
REQ-029 chnl_idx SHALL hold its last value after FIN until the next accepted start.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE and clear all counters, the sticky flag, weight1..9 (to 0), and chnl_idx.
REQ-031 rst=1 at a clock edge SHALL force conv_valid_o=0, conv_data_o=0, w_ready=0, pix_ready=0, busy=0 and done=0.
REQ-032 rst mid-job SHALL discard the job with no done pulse, and SHALL take priority over abort and start.

Verification
REQ-033 Basic: N=1, weights 1..9, 64 pixels 0..63 back-to-back, chnl_done 3 cycles after the last pixel -> weightK=K, conv_data_o=0..63 each 1 cycle after its handshake, done pulse once, busy low after.
REQ-034 Multi-channel: N=3, weights -1 then 2 then 127 (all taps), chnl_done per channel -> chnl_idx 0,1,2; taps stable per channel; exactly 3×64 conv_valid_o pulses; one done.
REQ-035 Backpressure/gaps: pix_valid toggling 1,0,1,0, w_valid with gaps -> conv_valid_o pattern equals the handshake pattern delayed by 1; no weight is skipped or duplicated.
REQ-036 Early done: chnl_done asserted together with the 64th pixel handshake -> sticky flag set; channel ends on the first DRAIN cycle; no hang.
REQ-037 Abort/reset: abort at pixel 20 of channel 1 -> IDLE next cycle, no done, weights unchanged; repeat with rst -> all outputs zero.
REQ-038 Edge: cfg_chnl_num=0 -> done one cycle after start, no beats consumed; start while busy -> no effect.
